// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the arbiter's requester-side and uarttx-side signals.
// slave  : the arbiter's view (consumes requests and uart_tx_busy).
// master : the environment's view (producers plus the uarttx).
// Debug signals: state_dbg carries the FSM state
//   (0 IDLE, 1 TAG, 2 ISSUE, 3 WAIT_HI, 4 WAIT_LO);
//   rr_ptr_dbg carries the round-robin pointer.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 8
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]              req_last;
    logic [NUM_REQ-1:0]              req_ready;
    logic                            uart_tx_en;
    logic [PAYLOAD_BITS-1:0]         uart_tx_data;
    logic                            uart_tx_busy;
    logic [GW-1:0]                   grant_id;
    logic                            active;
    logic                            timeout_pulse;
    logic [2:0]                      state_dbg;
    logic [GW-1:0]                   rr_ptr_dbg;

    modport slave (
        input  req_valid, req_data, req_last, uart_tx_busy,
        output req_ready, uart_tx_en, uart_tx_data, grant_id, active,
               timeout_pulse, state_dbg, rr_ptr_dbg
    );

    modport master (
        output req_valid, req_data, req_last, uart_tx_busy,
        input  req_ready, uart_tx_en, uart_tx_data, grant_id, active,
               timeout_pulse, state_dbg, rr_ptr_dbg
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uarttx between NUM_REQ byte-stream requesters.
// Round-robin arbitration at packet granularity; the grant is held until the
// byte flagged req_last has gone out. Exactly one uart_tx_en per busy frame.
// Optional feature: define UART_ARB_TAG_EN to prefix every packet with the
// tag byte TAG_BASE | grant_id.
//
// Handshake: a requester byte is transferred in the cycle where
// req_valid[i] & req_ready[i]; req_ready is a combinational 1-cycle pulse,
// only for the granted index and only in ISSUE, coincident with uart_tx_en.
module uart_tx_arbiter #(
    parameter int          NUM_REQ        = 4,
    parameter int          PAYLOAD_BITS   = 8,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter logic [7:0]  TAG_BASE       = 8'hF0
) (
    input  logic              clk,
    input  logic              resetn,
    uart_tx_arbiter_if.slave  bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TAG     = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              last_q, last_d;
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;

    logic [GW-1:0]           pick;
    logic [GW-1:0]           cand;
    logic                    found;
    logic [GW-1:0]           next_ptr;
    logic [PAYLOAD_BITS-1:0] req_bytes [NUM_REQ];

    // Unpack the flat data bus into one byte per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
        assign req_bytes[gi] = bus.req_data[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

`ifndef UART_ARB_TAG_EN
    wire unused_tag_base = ^TAG_BASE;
`endif

    // Pointer value after the current grant, wrapping NUM_REQ-1 -> 0.
    assign next_ptr = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;

    // Round-robin pick: first valid index scanning from rr_ptr upwards.
    always_comb begin
        pick  = rr_ptr_q;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = GW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state and combinational outputs of the packet sequencer.
    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        rr_ptr_d          = rr_ptr_q;
        last_d            = last_q;
        tmo_cnt_d         = tmo_cnt_q;
        bus.req_ready     = '0;
        bus.uart_tx_en    = 1'b0;
        bus.uart_tx_data  = '0;
        bus.timeout_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d   = pick;
                    tmo_cnt_d = '0;
                    // Cleared so the WAIT_LO after a tag byte returns to ISSUE.
                    last_d    = 1'b0;
`ifdef UART_ARB_TAG_EN
                    state_d   = ST_TAG;
`else
                    state_d   = ST_ISSUE;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG: begin
                bus.uart_tx_en   = 1'b1;
                bus.uart_tx_data = PAYLOAD_BITS'(TAG_BASE) | PAYLOAD_BITS'(grant_q);
                state_d          = ST_WAIT_HI;
            end
`endif
            ST_ISSUE: begin
                if (bus.req_valid[grant_q]) begin
                    bus.req_ready[grant_q] = 1'b1;
                    bus.uart_tx_en         = 1'b1;
                    bus.uart_tx_data       = req_bytes[grant_q];
                    last_d                 = bus.req_last[grant_q];
                    state_d                = ST_WAIT_HI;
                end else if (TIMEOUT_CYCLES != 0 && tmo_cnt_q == TMO_MAX) begin
                    bus.timeout_pulse = 1'b1;
                    rr_ptr_d          = next_ptr;
                    state_d           = ST_IDLE;
                end else if (tmo_cnt_q != TMO_MAX) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_WAIT_HI: begin
                if (bus.uart_tx_busy) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!bus.uart_tx_busy) begin
                    if (last_q) begin
                        rr_ptr_d = next_ptr;
                        state_d  = ST_IDLE;
                    end else begin
                        tmo_cnt_d = '0;
                        state_d   = ST_ISSUE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset drops any packet in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            last_q    <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            last_q    <= last_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign bus.grant_id   = grant_q;
    assign bus.active     = (state_q != ST_IDLE);
    assign bus.state_dbg  = state_q;
    assign bus.rr_ptr_dbg = rr_ptr_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: producers, a uarttx busy model, and a packet-level
// round-robin reference model predicting the byte stream on the line.
module tb_uart_tx_arbiter;
    localparam int         NREQ     = 4;
    localparam int         PB       = 8;
    localparam int         TMO      = 16;
    localparam logic [7:0] TAG_BASE = 8'hF0;
`ifdef UART_ARB_TAG_EN
    localparam int TAG_BYTES = 1;
`else
    localparam int TAG_BYTES = 0;
`endif
    localparam logic [2:0] DBG_IDLE    = 3'd0;
    localparam logic [2:0] DBG_ISSUE   = 3'd2;
    localparam logic [2:0] DBG_WAIT_LO = 3'd4;

    typedef logic [8:0] ent_t; // {last, data}

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ), .PAYLOAD_BITS(PB)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(NREQ), .PAYLOAD_BITS(PB), .TIMEOUT_CYCLES(TMO), .TAG_BASE(TAG_BASE)
    ) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    ent_t       src_q[NREQ][$];
    ent_t       mdl_q[NREQ][$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_gnt_q[$];
    logic [7:0] got_gnt_q[$];
    int         mdl_ptr;
    int         checks, errors;
    int         cyc, issue_entry, tp_count, tp_delay, en_count, busy_left;
    int         frame_min, frame_max;
    logic [2:0] prev_dbg;
    bit         start_of_pkt[NREQ];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_byte(input int r, input logic [7:0] d, input bit last);
        src_q[r].push_back({last, d});
        mdl_q[r].push_back({last, d});
    endtask

    task automatic add_pkt(input int r, input int len);
        for (int k = 0; k < len; k++) begin
            add_byte(r, 8'($urandom_range(0, 255)), k == len - 1);
        end
    endtask

    // Packet-level reference: whole packets, round-robin from the pointer;
    // a packet that runs out without its last byte is dropped by timeout,
    // which advances the pointer exactly as a completed packet does.
    task automatic model_run();
        int  g;
        bit  done;
        ent_t e;
        forever begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && mdl_q[(mdl_ptr + k) % NREQ].size() > 0) g = (mdl_ptr + k) % NREQ;
            end
            if (g < 0) break;
            exp_gnt_q.push_back(8'(g));
            if (TAG_BYTES != 0) exp_q.push_back(TAG_BASE | 8'(g));
            done = 1'b0;
            while (!done && mdl_q[g].size() > 0) begin
                e = mdl_q[g].pop_front();
                exp_q.push_back(e[7:0]);
                done = e[8];
            end
            mdl_ptr = (g + 1) % NREQ;
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0) begin
                bus.req_valid[i]        = 1'b1;
                bus.req_data[i*PB +: PB] = src_q[i][0][7:0];
                bus.req_last[i]         = src_q[i][0][8];
            end else begin
                bus.req_valid[i]        = 1'b0;
                bus.req_data[i*PB +: PB] = '0;
                bus.req_last[i]         = 1'b0;
            end
        end
    endtask

    // One clock: observe at the falling edge, update producers and the
    // uarttx busy model just after the rising edge.
    task automatic step();
        bit acc[NREQ];
        bit sf;
        int nready;
        sf = 1'b0;
        for (int i = 0; i < NREQ; i++) acc[i] = 1'b0;
        @(negedge clk);
        cyc++;
        if (bus.state_dbg == DBG_ISSUE && prev_dbg != DBG_ISSUE) issue_entry = cyc;
        prev_dbg = bus.state_dbg;
        if (bus.timeout_pulse) begin
            tp_count++;
            tp_delay = cyc - issue_entry;
        end
        nready = $countones(bus.req_ready);
        if (nready != 0) begin
            check("ready_onehot", nready, 1);
            check("ready_with_en", 32'(bus.uart_tx_en), 1);
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_ready[i]) begin
                    check("ready_is_grant", i, 32'(bus.grant_id));
                    if (bus.req_valid[i]) begin
                        acc[i] = 1'b1;
                        if (start_of_pkt[i]) got_gnt_q.push_back(8'(i));
                        start_of_pkt[i] = bus.req_last[i];
                    end
                end
            end
        end
        if (bus.uart_tx_en) begin
            check("en_while_busy", 32'(bus.uart_tx_busy), 0);
            if (TAG_BYTES == 0) check("en_has_ready", nready, 1);
            got_q.push_back(bus.uart_tx_data);
            en_count++;
            sf = 1'b1;
        end
        @(posedge clk);
        #1;
        if (sf) begin
            bus.uart_tx_busy = 1'b1;
            busy_left = $urandom_range(frame_min, frame_max);
        end else if (bus.uart_tx_busy) begin
            busy_left--;
            if (busy_left <= 0) bus.uart_tx_busy = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) void'(src_q[i].pop_front());
        end
        drive_inputs();
    endtask

    function automatic bit srcs_empty();
        for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_traffic(input string tag);
        int n;
        model_run();
        for (int i = 0; i < NREQ; i++) start_of_pkt[i] = 1'b1;
        drive_inputs();
        n = 0;
        while (!(srcs_empty() && !bus.active && !bus.uart_tx_busy) && n < 3000) begin
            step();
            n++;
        end
        check({tag, "_budget"}, 32'(n < 3000), 1);
        check({tag, "_line_len"}, got_q.size(), exp_q.size());
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            check({tag, "_line_byte"}, 32'(got_q[k]), 32'(exp_q[k]));
        end
        check({tag, "_grant_len"}, got_gnt_q.size(), exp_gnt_q.size());
        for (int k = 0; k < got_gnt_q.size() && k < exp_gnt_q.size(); k++) begin
            check({tag, "_grant"}, 32'(got_gnt_q[k]), 32'(exp_gnt_q[k]));
        end
        got_q.delete(); exp_q.delete(); got_gnt_q.delete(); exp_gnt_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.req_ready), 0);
        check({tag, "_en"}, 32'(bus.uart_tx_en), 0);
        check({tag, "_data"}, 32'(bus.uart_tx_data), 0);
        check({tag, "_active"}, 32'(bus.active), 0);
        check({tag, "_timeout"}, 32'(bus.timeout_pulse), 0);
        check({tag, "_grant_id"}, 32'(bus.grant_id), 0);
        check({tag, "_state"}, 32'(bus.state_dbg), 32'(DBG_IDLE));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, n;
        checks = 0; errors = 0; cyc = 0; tp_count = 0; tp_delay = 0; issue_entry = 0;
        en_count = 0; busy_left = 0; mdl_ptr = 0; frame_min = 2; frame_max = 6;
        prev_dbg = DBG_IDLE;
        resetn = 1'b0;
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.uart_tx_busy = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_rr_ptr", 32'(bus.rr_ptr_dbg), 0);
        @(negedge clk);
        resetn = 1'b1;

        // Requester 0 sends 11 22 33
        e0 = en_count;
        add_byte(0, 8'h11, 1'b0); add_byte(0, 8'h22, 1'b0); add_byte(0, 8'h33, 1'b1);
        run_traffic("req0_pkt");
        check("req0_en_count", en_count - e0, 3 + TAG_BYTES);
        check("req0_rr_ptr", 32'(bus.rr_ptr_dbg), 1);

        // Requesters 1 and 2 contend with two 2-byte packets each
        add_pkt(1, 2); add_pkt(2, 2); add_pkt(1, 2); add_pkt(2, 2);
        run_traffic("contend_1_2");

        // All four hold valid with single-byte packets
        for (int r = 0; r < 2; r++) for (int i = 0; i < NREQ; i++) add_pkt(i, 1);
        run_traffic("all_single");

        // Randomized packet mixes
        for (int round = 0; round < 8; round++) begin
            for (int i = 0; i < NREQ; i++) begin
                n = $urandom_range(0, 2);
                for (int p = 0; p < n; p++) add_pkt(i, $urandom_range(1, 4));
            end
            run_traffic("random");
        end
        check("no_spurious_timeout", tp_count, 0);

        // Requester 3 abandons a packet after its first byte
        add_byte(3, 8'h5A, 1'b0);
        run_traffic("timeout");
        check("timeout_count", tp_count, 1);
        check("timeout_delay", tp_delay, TMO);
        check("timeout_rr_ptr", 32'(bus.rr_ptr_dbg), 0);
        check("timeout_active", 32'(bus.active), 0);

        // Reset in the middle of WAIT_LO
        add_byte(1, 8'h77, 1'b1);
        run_traffic("pre_reset");
        frame_min = 10; frame_max = 10;
        src_q[2].push_back({1'b0, 8'hC1});
        src_q[2].push_back({1'b1, 8'hC2});
        for (int i = 0; i < NREQ; i++) start_of_pkt[i] = 1'b1;
        drive_inputs();
        e0 = en_count;
        n = 0;
        while (en_count == e0 && n < 50) begin step(); n++; end
        n = 0;
        while (!(bus.state_dbg == DBG_WAIT_LO && bus.uart_tx_busy) && n < 20) begin step(); n++; end
        check("pre_rst_state", 32'(bus.state_dbg), 32'(DBG_WAIT_LO));
        check("pre_rst_grant", 32'(bus.grant_id), 2);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        for (int i = 0; i < NREQ; i++) begin
            src_q[i].delete();
            mdl_q[i].delete();
        end
        got_q.delete(); exp_q.delete(); got_gnt_q.delete(); exp_gnt_q.delete();
        drive_inputs();
        bus.uart_tx_busy = 1'b0; busy_left = 0; mdl_ptr = 0; prev_dbg = DBG_IDLE;
        frame_min = 2; frame_max = 6;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_rr_ptr", 32'(bus.rr_ptr_dbg), 0);

        // After reset, requester 0 wins over requester 3
        add_pkt(3, 1); add_pkt(0, 2);
        run_traffic("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
